color_correction_sequencer: RTL and testbench

//  Time-multiplexed 3x3 colour-correction engine and its sequencer. It shares one signed

---
 rtl/cc_pkg.sv | 40 ++++
 rtl/cc_coef_bank.sv | 48 ++++
 rtl/color_correction_sequencer.sv | 134 +++++++++++++
 tb/tb_color_correction_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared widths, default colour matrix, FSM encoding and output clamp for the
// colour-correction engine.
package cc_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 11;
    localparam int SCALE  = 8;
    localparam int ACC_W  = DATA_W + COEF_W + 2;
    localparam int NCOEF  = 9;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Row-major C11..C33, 1.0 == 256
    localparam coef_t CC_DEFAULT [NCOEF] = '{
        11'sd430,  -11'sd127, -11'sd48,
        -11'sd55,  11'sd464,  -11'sd154,
        11'sd10,   -11'sd145, 11'sd391
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam acc_t RES_MAX = acc_t'((1 << DATA_W) - 1);

    function automatic logic [DATA_W-1:0] clamp(input acc_t acc);
        acc_t res;
        res = acc >>> SCALE;
        if (res < 0)
            return '0;
        else if (res > RES_MAX)
            return '1;
        else
            return res[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cc_coef_bank.sv
// Shadow/active coefficient banks. Shadow is written at any time; active is refreshed
// from shadow only while the engine is idle, so a pixel in flight sees one bank.
module cc_coef_bank
    import cc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  coef_t       cfg_data,
    input  logic        cfg_commit,
    input  logic        idle,
    input  logic [3:0]  rd_idx,
    output coef_t       rd_coef,
    output logic        commit_pend
);

    coef_t shadow [NCOEF];
    coef_t active [NCOEF];
    logic  copy;

    // A commit arriving in an idle cycle copies at that same edge, so the copy sees the
    // shadow contents from before any write issued in the same cycle.
    assign copy = idle && (commit_pend || cfg_commit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow[i] <= CC_DEFAULT[i];
                active[i] <= CC_DEFAULT[i];
            end
            commit_pend <= 1'b0;
        end else begin
            if (cfg_we && (cfg_addr <= 4'd8))
                shadow[cfg_addr] <= cfg_data;
            if (copy) begin
                for (int i = 0; i < NCOEF; i++)
                    active[i] <= shadow[i];
                commit_pend <= 1'b0;
            end else if (cfg_commit) begin
                commit_pend <= 1'b1;
            end
        end
    end

    assign rd_coef = active[rd_idx];

endmodule

// File: rtl/color_correction_sequencer.sv
// 3x3 colour correction sharing one signed MAC over 9 cycles per pixel; output clamped
// to unsigned DATA_W. One pixel in flight; in_ready only when idle, output holds on stall.
module color_correction_sequencer
    import cc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_g,
    output logic [DATA_W-1:0] out_b,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        step;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;
    logic [DATA_W-1:0] chan_r;
    logic [DATA_W-1:0] chan_g;
    logic [DATA_W-1:0] chan_b;
    logic [DATA_W-1:0] chan_sel;
    acc_t              acc [3];
    acc_t              chan_ext;
    acc_t              coef_ext;
    acc_t              term;
    acc_t              acc_sum;
    coef_t             coef;
    logic              commit_pend;
    logic              idle;
    logic              accept;

    assign idle      = (state == ST_IDLE);
    assign in_ready  = idle;
    assign busy      = !idle;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && idle;

    cc_coef_bank u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .idle        (idle),
        .rd_idx      (step),
        .rd_coef     (coef),
        .commit_pend (commit_pend)
    );

    always_comb begin
        case (col_idx)
            2'd0:    chan_sel = chan_r;
            2'd1:    chan_sel = chan_g;
            default: chan_sel = chan_b;
        endcase
    end

    // Both operands widened to ACC_W so neither the product nor the sum can wrap.
    assign chan_ext = {{(ACC_W-DATA_W){1'b0}}, chan_sel};
    assign coef_ext = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
    assign term     = chan_ext * coef_ext;
    assign acc_sum  = acc[row_idx] + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)      state_nxt = ST_MAC;
            ST_MAC:  if (step == 4'd8)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready)     state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= '0;
            col_idx <= '0;
            row_idx <= '0;
            chan_r  <= '0;
            chan_g  <= '0;
            chan_b  <= '0;
            for (int i = 0; i < 3; i++)
                acc[i] <= '0;
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
        end else if (accept) begin
            chan_r  <= in_r;
            chan_g  <= in_g;
            chan_b  <= in_b;
            step    <= '0;
            col_idx <= '0;
            row_idx <= '0;
            for (int i = 0; i < 3; i++)
                acc[i] <= '0;
        end else if (state == ST_MAC) begin
            acc[row_idx] <= acc_sum;
            step         <= step + 4'd1;
            if (col_idx == 2'd2) begin
                col_idx <= '0;
                row_idx <= row_idx + 2'd1;
            end else begin
                col_idx <= col_idx + 2'd1;
            end
            // Last term belongs to the blue row, so blue clamps from the fresh sum.
            if (step == 4'd8) begin
                out_r <= clamp(acc[0]);
                out_g <= clamp(acc[1]);
                out_b <= clamp(acc_sum);
            end
        end
    end

endmodule

// File: tb/tb_color_correction_sequencer.sv
// Randomized and directed bench for the colour-correction engine against a
// matrix-multiply reference with its own shadow/active coefficient model.
module tb_color_correction_sequencer;
    import cc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] in_r, in_g, in_b, out_r, out_g, out_b;
    logic        cfg_we, cfg_commit;
    logic [3:0]  cfg_addr;
    logic [10:0] cfg_data;

    int n_tests = 0;
    int n_fail  = 0;

    int  m_shadow [9];
    int  m_active [9];
    bit  m_pend;
    int  def_coef [9] = '{430, -127, -48, -55, 464, -154, 10, -145, 391};

    logic [15:0] obs_r, obs_g, obs_b;

    always #5 clk = ~clk;

    color_correction_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_chan(input int c0, input int c1, input int c2,
                                    input int r, input int g, input int b);
        longint s;
        s = longint'(c0) * r + longint'(c1) * g + longint'(c2) * b;
        s = s >>> 8;
        if (s < 0)     return 0;
        if (s > 65535) return 65535;
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_shadow[i] = def_coef[i];
            m_active[i] = def_coef[i];
        end
        m_pend = 1'b0;
    endtask

    // One cfg cycle issued while the engine is idle.
    task automatic cfg_cycle(input bit we, input int addr, input int data, input bit commit);
        logic [10:0] d;
        d = data[10:0];
        @(negedge clk);
        cfg_we = we; cfg_addr = addr[3:0]; cfg_data = d; cfg_commit = commit;
        if (commit) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        if (we && addr <= 8)
            m_shadow[addr] = int'($signed(d));
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                              input int stall, input bit mid_cfg, input int mid_addr,
                              input int mid_data, input string tag);
        int lat, er, eg, eb, w;
        logic [10:0] md;
        md = mid_data[10:0];
        @(negedge clk);
        in_valid = 1'b1; in_r = r; in_g = g; in_b = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk); w++;
        end
        check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        if (m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        er = ref_chan(m_active[0], m_active[1], m_active[2], r, g, b);
        eg = ref_chan(m_active[3], m_active[4], m_active[5], r, g, b);
        eb = ref_chan(m_active[6], m_active[7], m_active[8], r, g, b);
        @(negedge clk);
        in_valid = 1'b0;
        in_r = 16'($urandom); in_g = 16'($urandom); in_b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (mid_cfg && lat == 3) begin
                cfg_we = 1'b1; cfg_addr = mid_addr[3:0]; cfg_data = md; cfg_commit = 1'b1;
                if (mid_addr <= 8) m_shadow[mid_addr] = int'($signed(md));
                m_pend = 1'b1;
            end else begin
                cfg_we = 1'b0; cfg_commit = 1'b0;
            end
            @(negedge clk); lat++;
        end
        cfg_we = 1'b0; cfg_commit = 1'b0;
        check({tag, "_latency"}, lat, 10);
        obs_r = out_r; obs_g = out_g; obs_b = out_b;
        check({tag, "_r"}, {16'd0, out_r}, er);
        check({tag, "_g"}, {16'd0, out_g}, eg);
        check({tag, "_b"}, {16'd0, out_b}, eb);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (out_r !== er[15:0] || out_g !== eg[15:0] || out_b !== eb[15:0] ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                check({tag, "_hold"}, {out_valid, in_ready, 14'd0, out_r}, {2'b10, 14'd0, er[15:0]});
            else
                n_tests++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drained"}, {30'd0, in_ready, busy}, {30'd0, 2'b10});
    endtask

    initial begin
        int r, g, b;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", {28'd0, in_ready, out_valid, busy, 1'b0}, {28'd0, 4'b1000});
        check("rst_out", {out_r, out_g}, 32'd0);
        check("rst_out_b", {16'd0, out_b}, 32'd0);
        rst_n = 1'b1;

        send_pixel(16'd51200, 16'd0, 16'd0, 0, 1'b0, 0, 0, "t1");
        check("t1_const", {obs_r, obs_g}, {16'd65535, 16'd0});
        check("t1_const_b", {16'd0, obs_b}, 32'd2000);

        send_pixel(16'd51200, 16'd46080, 16'd40960, 0, 1'b0, 0, 0, "t2");
        check("t2_const", {obs_r, obs_g}, {16'd55460, 16'd47880});
        check("t2_const_b", {16'd0, obs_b}, 32'd38460);

        for (int i = 0; i < 9; i++)
            cfg_cycle(1'b1, i, (i % 4 == 0) ? 256 : 0, 1'b0);
        cfg_cycle(1'b0, 0, 0, 1'b1);
        send_pixel(16'd1234, 16'd0, 16'd65535, 0, 1'b0, 0, 0, "t3");
        check("t3_const", {obs_r, obs_g}, {16'd1234, 16'd0});
        check("t3_const_b", {16'd0, obs_b}, 32'd65535);

        cfg_cycle(1'b1, 0, 512, 1'b1);
        send_pixel(16'd1000, 16'd0, 16'd0, 0, 1'b0, 0, 0, "simul_pre");
        check("simul_pre_const", {16'd0, obs_r}, 32'd1000);
        cfg_cycle(1'b1, 12, 100, 1'b1);
        send_pixel(16'd1000, 16'd0, 16'd0, 0, 1'b0, 0, 0, "simul_post");
        check("simul_post_const", {16'd0, obs_r}, 32'd2000);

        send_pixel(16'd3000, 16'd4000, 16'd5000, 20, 1'b0, 0, 0, "t4");

        send_pixel(16'd10000, 16'd0, 16'd0, 0, 1'b1, 0, 768, "t5a");
        check("t5a_old_bank", {16'd0, obs_r}, 32'd20000);
        send_pixel(16'd10000, 16'd0, 16'd0, 0, 1'b0, 0, 0, "t5b");
        check("t5b_new_bank", {16'd0, obs_r}, 32'd30000);

        @(negedge clk);
        in_valid = 1'b1; in_r = 16'd51200; in_g = 16'd46080; in_b = 16'd40960;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
        check("t6_rst_out", {out_r, out_b}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cfg_cycle(1'b0, 0, 0, 1'b1);
        send_pixel(16'd51200, 16'd46080, 16'd40960, 0, 1'b0, 0, 0, "t6");
        check("t6_const", {obs_r, obs_g}, {16'd55460, 16'd47880});

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 3; k++)
                    cfg_cycle(1'b1, $urandom_range(0, 15), $urandom_range(0, 2047) - 1024, 1'b0);
                cfg_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                          $urandom_range(0, 2047) - 1024, 1'b1);
            end
            r = $urandom_range(0, 65535);
            g = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            send_pixel(r[15:0], g[15:0], b[15:0], $urandom_range(0, 3),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 9),
                       $urandom_range(0, 2047) - 1024, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
